// File: rtl/avl_mem_responder_if.sv
// Avalon-MM request/response bundle between the frame buffer and the memory responder.
interface avl_mem_if #(
    parameter int unsigned ADDR_WIDTH = 29,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  avl_write_req;
    logic                  avl_read_req;
    logic [ADDR_WIDTH-1:0] avl_addr;
    logic [DATA_WIDTH-1:0] avl_wdata;
    logic                  avl_ready;
    logic [DATA_WIDTH-1:0] avl_rdata;
    logic                  avl_rdata_valid;

    modport master (
        output avl_write_req, avl_read_req, avl_addr, avl_wdata,
        input  avl_ready, avl_rdata, avl_rdata_valid
    );

    modport slave (
        input  avl_write_req, avl_read_req, avl_addr, avl_wdata,
        output avl_ready, avl_rdata, avl_rdata_valid
    );
endinterface

// File: rtl/avl_mem_responder.sv
// Avalon-MM memory responder: calibration delay, periodic wait-request stalls,
// on-chip storage and fixed-latency in-order read return.
module avl_mem_responder #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 29,
    parameter int unsigned RAM_AWIDTH   = 10,
    parameter int unsigned RD_LATENCY   = 4,
    parameter int unsigned INIT_CYCLES  = 64,
    parameter int unsigned STALL_PERIOD = 8
) (
    input  logic     clk,
    input  logic     reset,
    avl_mem_if.slave avl,
    output logic     ram_rdy,
    output logic     proto_err
);

    localparam int unsigned DEPTH      = 2 ** RAM_AWIDTH;
    localparam int unsigned INIT_W     = $clog2(INIT_CYCLES + 1);
    localparam int unsigned STALL_W    = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
    localparam int unsigned STALL_LAST = (STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic                 ram_rdy_q, ram_rdy_d;
    logic                 avl_ready_q, avl_ready_d;
    logic                 proto_err_q;
    logic                 rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [RD_LATENCY-1:0] pv_q;
    logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];

    logic                  rd_acc;
    logic                  wr_acc;
    logic                  both_req;
    logic [RAM_AWIDTH-1:0] ram_idx;

    // Request acceptance; a simultaneous read+write services only the read.
    assign both_req = avl_ready_q & avl.avl_read_req & avl.avl_write_req;
    assign rd_acc   = avl_ready_q & avl.avl_read_req;
    assign wr_acc   = avl_ready_q & avl.avl_write_req & ~avl.avl_read_req;
    assign ram_idx  = avl.avl_addr[RAM_AWIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // Next state: leave INIT once the calibration count is reached.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt_q == INIT_W'(INIT_CYCLES)) begin
            state_d = ST_RUN;
        end
    end

    // Next values of counters and registered status outputs.
    always_comb begin
        init_cnt_d  = init_cnt_q;
        stall_cnt_d = stall_cnt_q;
        ram_rdy_d   = 1'b0;
        avl_ready_d = 1'b0;
        if (state_d == ST_INIT) begin
            if (init_cnt_q != INIT_W'(INIT_CYCLES)) init_cnt_d = init_cnt_q + 1'b1;
        end else begin
            ram_rdy_d = 1'b1;
            if (state_q == ST_INIT) begin
                stall_cnt_d = '0;
            end else if (STALL_PERIOD != 0) begin
                stall_cnt_d = (stall_cnt_q == STALL_W'(STALL_LAST)) ? '0 : stall_cnt_q + 1'b1;
            end
            avl_ready_d = (STALL_PERIOD == 0) || (stall_cnt_d != STALL_W'(STALL_LAST));
        end
    end

    // Counter and status registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            init_cnt_q  <= '0;
            stall_cnt_q <= '0;
            ram_rdy_q   <= 1'b0;
            avl_ready_q <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            ram_rdy_q   <= ram_rdy_d;
            avl_ready_q <= avl_ready_d;
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (!reset)        proto_err_q <= 1'b0;
        else if (both_req) proto_err_q <= 1'b1;
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[ram_idx] <= avl.avl_wdata;
    end

    // Read data path: synchronous read then shift, no reset needed on data.
    always_ff @(posedge clk) begin
        if (rd_acc) pd_q[0] <= mem[ram_idx];
        for (int i = 1; i < RD_LATENCY; i++) pd_q[i] <= pd_q[i-1];
    end

    // Read valid path; reset flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= rd_acc;
            for (int i = 1; i < RD_LATENCY; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    // Response output registers; data holds between pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pv_q[RD_LATENCY-1];
            if (pv_q[RD_LATENCY-1]) rdata_q <= pd_q[RD_LATENCY-1];
        end
    end

    assign avl.avl_ready       = avl_ready_q;
    assign avl.avl_rdata       = rdata_q;
    assign avl.avl_rdata_valid = rvalid_q;
    assign ram_rdy             = ram_rdy_q;
    assign proto_err           = proto_err_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Directed bench for avl_mem_responder: init timing, vector table, streaming and mid-read reset.
module tb_avl_mem_responder;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 29;
    localparam int unsigned RAW    = 10;
    localparam int unsigned RD_LAT = 4;
    localparam int unsigned INIT_C = 16;
    localparam int unsigned STALLP = 8;

    logic clk = 1'b0;
    logic reset;
    logic ram_rdy;
    logic proto_err;

    avl_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    avl_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_AWIDTH(RAW),
        .RD_LATENCY(RD_LAT), .INIT_CYCLES(INIT_C), .STALL_PERIOD(STALLP)
    ) dut (
        .clk(clk), .reset(reset), .avl(bus), .ram_rdy(ram_rdy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int vq_cyc[$];
    logic [DW-1:0] vq_dat[$];
    int acc_e[8];
    int stalls;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_perr;
    } vec_t;

    vec_t vt[10];

    // Edge counter and read-response log sampled on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.avl_rdata_valid === 1'b1) begin
            vq_cyc.push_back(cyc);
            vq_dat.push_back(bus.avl_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int acc);
        logic r;
        acc = -1;
        bus.avl_write_req = wr;
        bus.avl_read_req  = rd;
        bus.avl_addr      = a;
        bus.avl_wdata     = d;
        for (int t = 0; t < 32; t++) begin
            r = bus.avl_ready;
            step();
            if (r === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        bus.avl_write_req = 1'b0;
        bus.avl_read_req  = 1'b0;
        if (acc < 0) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic check_read(input string name, input int acc, input logic [DW-1:0] exp);
        int c;
        logic [DW-1:0] d;
        for (int t = 0; t < int'(RD_LAT) + 4 && vq_cyc.size() == 0; t++) step();
        if (vq_cyc.size() == 0) begin
            chk({name, "_missing"}, 32'(0), 32'(1));
        end else begin
            c = vq_cyc.pop_front();
            d = vq_dat.pop_front();
            chk({name, "_lat"}, 32'(c), 32'(acc + int'(RD_LAT)));
            chk({name, "_data"}, d, exp);
        end
    endtask

    task automatic init_seq(input string name);
        for (int k = 0; k <= int'(INIT_C); k++) begin
            step();
            chk($sformatf("%s_rdy%0d", name, k), 32'(ram_rdy), 32'(k == int'(INIT_C)));
            chk($sformatf("%s_ready%0d", name, k), 32'(bus.avl_ready), 32'(k == int'(INIT_C)));
            if (k == int'(INIT_C)) bus.avl_read_req = 1'b0;
        end
    endtask

    task automatic wait_stall();
        for (int t = 0; t < 20; t++) begin
            if (bus.avl_ready === 1'b0) break;
            step();
        end
        step();
    endtask

    task automatic stream(input int n);
        int i;
        logic r;
        i = 0;
        stalls = 0;
        for (int t = 0; t < 40 && i < n; t++) begin
            bus.avl_addr     = AW'(i);
            bus.avl_read_req = 1'b1;
            r = bus.avl_ready;
            step();
            if (r === 1'b1) begin
                acc_e[i] = cyc;
                i++;
            end else begin
                stalls++;
            end
        end
        bus.avl_read_req = 1'b0;
        if (i < n) chk("stream_timeout", 32'(i), 32'(n));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ram_rdy"}, 32'(ram_rdy), 32'(0));
        chk({name, "_ready"}, 32'(bus.avl_ready), 32'(0));
        chk({name, "_valid"}, 32'(bus.avl_rdata_valid), 32'(0));
        chk({name, "_rdata"}, bus.avl_rdata, 32'(0));
        chk({name, "_perr"}, 32'(proto_err), 32'(0));
    endtask

    initial begin
        int acc;

        vt[0] = '{1'b1, 1'b0, 29'h0000005, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1] = '{1'b0, 1'b1, 29'h0000005, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b1, 1'b0, 29'h0000405, 32'hA5A5A5A5, 32'h0,        1'b0};
        vt[3] = '{1'b0, 1'b1, 29'h0000005, 32'h0,        32'hA5A5A5A5, 1'b0};
        vt[4] = '{1'b1, 1'b0, 29'h0000003, 32'h33333333, 32'h0,        1'b0};
        vt[5] = '{1'b0, 1'b1, 29'h0000003, 32'h0,        32'h33333333, 1'b0};
        vt[6] = '{1'b1, 1'b1, 29'h0000003, 32'h00000011, 32'h33333333, 1'b1};
        vt[7] = '{1'b0, 1'b1, 29'h0000003, 32'h0,        32'h33333333, 1'b1};
        vt[8] = '{1'b1, 1'b0, 29'h1FFFFFFF, 32'h12345678, 32'h0,       1'b1};
        vt[9] = '{1'b0, 1'b1, 29'h00003FF, 32'h0,        32'h12345678, 1'b1};

        reset             = 1'b0;
        bus.avl_write_req = 1'b0;
        bus.avl_read_req  = 1'b0;
        bus.avl_addr      = '0;
        bus.avl_wdata     = '0;
        step();
        step();
        check_reset_outputs("rst0");

        // Release reset with a read already held; nothing may be accepted during INIT.
        reset            = 1'b1;
        bus.avl_read_req = 1'b1;
        bus.avl_addr     = AW'(5);
        init_seq("init");
        for (int t = 0; t < 8; t++) step();
        chk("init_no_valid", 32'(vq_cyc.size()), 32'(0));

        for (int i = 0; i < 10; i++) begin
            issue(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata, acc);
            if (vt[i].rd) check_read($sformatf("vec%0d", i), acc, vt[i].exp_rdata);
            chk($sformatf("vec%0d_perr", i), 32'(proto_err), 32'(vt[i].exp_perr));
        end

        // Streaming: eight writes then eight back-to-back reads spanning one stall.
        for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, AW'(i), DW'(32'h100 + i), acc);
        wait_stall();
        stream(8);
        chk("stream_stalls", 32'(stalls), 32'(1));
        for (int i = 0; i < 8; i++) check_read($sformatf("stream%0d", i), acc_e[i], DW'(32'h100 + i));

        // Mid-read reset: three reads in flight are flushed before any returns.
        wait_stall();
        stream(3);
        step();
        reset = 1'b0;
        step();
        check_reset_outputs("rst1");
        step();
        reset = 1'b1;
        init_seq("reinit");
        for (int t = 0; t < 8; t++) step();
        chk("flush_no_valid", 32'(vq_cyc.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
